// File: rtl/slow_mem_pkg.sv
// Shared types and widths for the slow-memory line responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slow_mem_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;
endpackage

// File: rtl/slow_mem_array.sv
// Line storage: 2^DEPTH_LOG2 lines, combinational read port, synchronous write port.
// Latency: read 0 cycles, write visible after the clock edge.
// Backpressure: none.
module slow_mem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_W     = 128
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [LINE_W-1:0]     rdata,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [LINE_W-1:0]     wdata
);
  // Contents are deliberately not reset.
  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  assign rdata = mem[raddr];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/slow_mem_responder.sv
// Memory-side responder for the cache line interface: one 128-bit read or write per request.
// Latency: request sampled at edge k, mem_ready is seen by the cache at edge k+LATENCY.
// Backpressure: none; request lines are ignored while a transaction is in flight.
module slow_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_W     = 128
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mem_read,
  input  logic                            mem_write,
  input  logic [slow_mem_pkg::ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]               mem_wdata,
  output logic [LINE_W-1:0]               mem_rdata,
  output logic                            mem_ready,
  output logic                            busy,
  output logic                            proto_err
);
  import slow_mem_pkg::*;

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  capture;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [LINE_W-1:0]     wdata_q;
  logic [LINE_W-1:0]     rdata_q;
  logic [LINE_W-1:0]     arr_rdata;
  logic                  arr_we;
  logic                  unused_addr_hi;

  // Address bits above the index simply alias onto the same line.
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  slow_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LINE_W     (LINE_W)
  ) u_array (
    .clk   (clk),
    .raddr (idx),
    .rdata (arr_rdata),
    .we    (arr_we),
    .waddr (idx),
    .wdata (wdata_q)
  );

  // Next-state: BUSY counts down from LATENCY-1 and hands over to READY when it reaches 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = READY;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = READY;
      end
      READY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch, last-read holding register and sticky protocol flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        // Read and write together is resolved as a write.
        op_wr   <= mem_write;
        idx     <= mem_addr[DEPTH_LOG2-1:0];
        wdata_q <= mem_wdata;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end
      if (state == READY && !op_wr) rdata_q <= arr_rdata;
    end
  end

  // Writes commit at the end of READY, so a following read never sees stale data.
  assign arr_we    = (state == READY) && op_wr;
  assign mem_ready = (state == READY);
  assign busy      = (state != IDLE);
  assign mem_rdata = (state == READY && !op_wr) ? arr_rdata : rdata_q;
endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: four latencies side by side on shared request lines.
// Latency: n/a.
// Backpressure: n/a.
module tb_slow_mem_responder;
  localparam int NI = 4;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [27:0]   mem_addr = '0;
  logic [127:0]  mem_wdata = '0;
  logic [127:0]  rdata_o [NI];
  logic          ready_o [NI];
  logic          busy_o  [NI];
  logic          perr_o  [NI];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = lat_of(g);

    slow_mem_responder #(
      .LATENCY    (L),
      .DEPTH_LOG2 (10),
      .LINE_W     (128)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (rdata_o[g]),
      .mem_ready (ready_o[g]),
      .busy      (busy_o[g]),
      .proto_err (perr_o[g])
    );

    // Transaction-level reference: absolute edge numbers, a sparse line store, one pending op.
    logic [127:0] mem [int];
    int           e;
    bit           inflight;
    int           done_e;
    bit           op_w;
    int           idx;
    logic [127:0] wd;
    logic [127:0] rd;
    bit           rd_known;
    bit           perr;
    bit           exp_rdy;
    logic [127:0] exp_rd;
    bit           rd_cmp;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e = 0; inflight = 0; rd = '0; rd_known = 1; perr = 0;
      end else begin
        e++;
        if (inflight && e == done_e) begin
          if (op_w) begin
            mem[idx] = wd;
          end else begin
            rd_known = mem.exists(idx);
            rd = rd_known ? mem[idx] : '0;
          end
          inflight = 0;
        end else if (!inflight && (mem_read || mem_write)) begin
          inflight = 1;
          done_e   = e + L;
          op_w     = mem_write;
          idx      = int'(mem_addr[9:0]);
          wd       = mem_wdata;
          if (mem_read && mem_write) perr = 1;
        end
      end
    end

    always @(negedge clk) begin
      exp_rdy = inflight && (e == done_e - 1);
      exp_rd  = rd;
      rd_cmp  = rd_known;
      if (exp_rdy && !op_w) begin
        rd_cmp = mem.exists(idx);
        exp_rd = rd_cmp ? mem[idx] : '0;
      end
      chk($sformatf("L%0d mem_ready", L), 128'(ready_o[g]), 128'(exp_rdy));
      chk($sformatf("L%0d busy", L), 128'(busy_o[g]), 128'(inflight));
      chk($sformatf("L%0d proto_err", L), 128'(perr_o[g]), 128'(perr));
      if (rd_cmp) chk($sformatf("L%0d mem_rdata", L), rdata_o[g], exp_rd);
    end
  end

  // Drive one request on instance 0 (LATENCY=4) and report the pulse distance and read line.
  task automatic do_txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                        input bit hold, output int lat, output logic [127:0] rdat);
    int n;
    n = 0;
    while (busy_o[0] && n < 50) begin @(negedge clk); n++; end
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    lat = 0; rdat = '0;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (!hold && t == 1) begin mem_read = 1'b0; mem_write = 1'b0; end
      if (ready_o[0]) begin
        lat = t; rdat = rdata_o[0];
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
  localparam logic [127:0] D2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] D3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] D4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] A5 = {16{8'hA5}};

  initial begin
    int           lat;
    logic [127:0] rdat;
    int           first_t [NI];
    int           last_t  [NI];
    int           r;
    logic [27:0]  addr_tab [8];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset release.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("idle ready", 128'(ready_o[i]), 128'd0);
        chk("idle busy", 128'(busy_o[i]), 128'd0);
        chk("idle rdata", rdata_o[i], 128'd0);
      end
    end

    // Write then read back the same line.
    do_txn(1'b0, 1'b1, 28'h0000010, D1, 1'b1, lat, rdat);
    chk("write latency", 128'(lat), 128'd4);
    do_txn(1'b1, 1'b0, 28'h0000010, '0, 1'b1, lat, rdat);
    chk("read latency", 128'(lat), 128'd4);
    chk("read back 0x10", rdat, D1);
    @(negedge clk);
    chk("rdata held after read", rdata_o[0], D1);

    // Read request dropped one cycle after sampling.
    do_txn(1'b0, 1'b1, 28'h0000011, D2, 1'b1, lat, rdat);
    do_txn(1'b1, 1'b0, 28'h0000011, '0, 1'b0, lat, rdat);
    chk("dropped read latency", 128'(lat), 128'd4);
    chk("dropped read data", rdat, D2);
    @(negedge clk);
    chk("rdata unchanged after write", rdata_o[0], D2);

    // Read and write together: write wins, sticky error.
    chk("proto_err clear", 128'(perr_o[0]), 128'd0);
    do_txn(1'b1, 1'b1, 28'h0000020, A5, 1'b1, lat, rdat);
    chk("both latency", 128'(lat), 128'd4);
    chk("proto_err set", 128'(perr_o[0]), 128'd1);
    do_txn(1'b1, 1'b0, 28'h0000020, '0, 1'b1, lat, rdat);
    chk("read 0x20", rdat, A5);
    chk("proto_err sticky", 128'(perr_o[0]), 128'd1);

    // Address aliasing above the index bits.
    do_txn(1'b0, 1'b1, 28'h0000400, 128'h1, 1'b1, lat, rdat);
    do_txn(1'b1, 1'b0, 28'h0000000, '0, 1'b1, lat, rdat);
    chk("alias read", rdat, 128'h1);

    // Reset two cycles into BUSY of a write aborts it.
    do_txn(1'b0, 1'b1, 28'h0000030, D3, 1'b1, lat, rdat);
    while (busy_o[0]) @(negedge clk);
    mem_write = 1'b1; mem_addr = 28'h0000030; mem_wdata = D4;
    repeat (3) @(negedge clk);
    mem_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort ready", 128'(ready_o[0]), 128'd0);
    chk("abort busy", 128'(busy_o[0]), 128'd0);
    chk("abort rdata", rdata_o[0], 128'd0);
    chk("abort proto_err", 128'(perr_o[0]), 128'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort no ready", 128'(ready_o[0]), 128'd0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 28'h0000030, '0, 1'b1, lat, rdat);
    chk("aborted line kept", rdat, D3);

    // Held read on all latencies: first pulse at LATENCY, then every LATENCY+1.
    do_reset();
    for (int i = 0; i < NI; i++) begin first_t[i] = 0; last_t[i] = 0; end
    mem_read = 1'b1; mem_addr = 28'h0000010;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (ready_o[i]) begin
          if (first_t[i] == 0) first_t[i] = t;
          else chk($sformatf("L%0d spacing", lat_of(i)), 128'(t - last_t[i]), 128'(lat_of(i) + 1));
          last_t[i] = t;
        end
      end
    end
    mem_read = 1'b0;
    for (int i = 0; i < NI; i++)
      chk($sformatf("L%0d first pulse", lat_of(i)), 128'(first_t[i]), 128'(lat_of(i)));

    // Random traffic, level-style, checked only by the reference model.
    addr_tab[0] = 28'h0000010; addr_tab[1] = 28'h0000011; addr_tab[2] = 28'h0000020;
    addr_tab[3] = 28'h0000030; addr_tab[4] = 28'h0000400; addr_tab[5] = 28'h0000410;
    addr_tab[6] = 28'hABCD411; addr_tab[7] = 28'h0000000;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 9));
      mem_read  = (r < 3) || (r == 5);
      mem_write = (r == 3) || (r == 4) || (r == 5);
      mem_addr  = addr_tab[$urandom_range(0, 7)];
      mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
